// File: rtl/hs32_pkg.sv
// Shared HS32 constants, fetch FSM state encoding and address helpers.
package hs32_pkg;

    localparam int          HS32_WORD_W   = 32;
    localparam logic [31:0] HS32_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] HS32_PC_INC   = 32'd4;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQ     = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/hs32_fetch_if.sv
// Fetch unit bus bundle: memory read port, decode handshake and execute redirect.
interface hs32_fetch_if;
    import hs32_pkg::*;

    logic [HS32_WORD_W-1:0] addr;
    logic                   reqm;
    logic [HS32_WORD_W-1:0] rdata;
    logic                   ackm;
    logic [HS32_WORD_W-1:0] instd;
    logic [HS32_WORD_W-1:0] pcd;
    logic                   ackd;
    logic                   reqd;
    logic                   flush;
    logic [HS32_WORD_W-1:0] newpc;

    modport master (
        output addr, reqm, instd, pcd, ackd,
        input  rdata, ackm, reqd, flush, newpc
    );

    modport slave (
        input  addr, reqm, instd, pcd, ackd,
        output rdata, ackm, reqd, flush, newpc
    );

endinterface

// File: rtl/hs32_fifo.sv
// Small synchronous FIFO with clear and a combinational head; DEPTH must be a power of two.
module hs32_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is reset too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/hs32_fetch.sv
// HS32 instruction fetch: sequential PC, memory read FSM, prefetch queue and redirect handling.
module hs32_fetch
    import hs32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = HS32_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic clk,
    input  logic reset,
    hs32_fetch_if.master bus
);

    localparam int          CW         = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [31:0] RESET_PC_A = word_align(RESET_PC);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;

    logic [CW-1:0] count;
    logic [CW-1:0] count_after_pop;
    logic [63:0]   head;
    logic          push;
    logic          pop;
    logic          ackd_c;

    hs32_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .din   ({bus.rdata, addr_q}),
        .pop   (pop),
        .clear (bus.flush),
        .dout  (head),
        .count (count)
    );

    // Space checks use occupancy after a same-edge pop so streaming never stalls.
    always_comb begin
        ackd_c          = (count != '0) && !bus.flush;
        pop             = ackd_c && bus.reqd;
        count_after_pop = count - CW'(pop);
        state_d         = state_q;
        pc_d            = pc_q;
        addr_d          = addr_q;
        push            = 1'b0;

        case (state_q)
            FETCH_IDLE: begin
                if (bus.flush) begin
                    pc_d = word_align(bus.newpc);
                end else if (count_after_pop < DEPTH_C) begin
                    addr_d  = pc_q;
                    state_d = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (bus.flush) begin
                    pc_d    = word_align(bus.newpc);
                    state_d = bus.ackm ? FETCH_IDLE : FETCH_DISCARD;
                end else if (bus.ackm) begin
                    push = 1'b1;
                    pc_d = pc_q + HS32_PC_INC;
                    if (count_after_pop < DEPTH_C - CW'(1)) begin
                        addr_d = pc_q + HS32_PC_INC;
                    end else begin
                        state_d = FETCH_IDLE;
                    end
                end
            end
            FETCH_DISCARD: begin
                // addr stays put: the arbiter still owns the flushed read.
                if (bus.flush) begin
                    pc_d = word_align(bus.newpc);
                end
                if (bus.ackm) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC_A;
            addr_q  <= RESET_PC_A;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.addr  = addr_q;
    assign bus.reqm  = (state_q != FETCH_IDLE);
    assign bus.instd = head[63:32];
    assign bus.pcd   = head[31:0];
    assign bus.ackd  = ackd_c;

endmodule
